// File: rtl/vga_timing_gen.sv
// Raster timing generator: h/v counters advancing on pix_en, with registered
// sync/de/coordinate/strobe decode so every output changes on the same clk.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CW       = 11
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pix_en,
  input  logic          run,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          line_start,
  output logic          frame_start,
  output logic          vblank
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] H_SS   = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] H_SE   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] V_SS   = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] V_SE   = CW'(V_ACTIVE + V_FP + V_SYNC);

  logic [CW-1:0] r_h, r_v;
  logic          w_h_last, w_v_last;
  logic          w_de, w_hs_on, w_vs_on, w_vblank;

  assign w_h_last = (r_h == H_LAST);
  assign w_v_last = (r_v == V_LAST);
  assign w_de     = (r_h < H_ACT) && (r_v < V_ACT);
  assign w_hs_on  = (r_h >= H_SS) && (r_h < H_SE);
  assign w_vs_on  = (r_v >= V_SS) && (r_v < V_SE);
  assign w_vblank = (r_v >= V_ACT);

  // Dropping run abandons the frame immediately, independent of pix_en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h <= '0;
      r_v <= '0;
    end else if (!run) begin
      r_h <= '0;
      r_v <= '0;
    end else if (pix_en) begin
      if (w_h_last) begin
        r_h <= '0;
        r_v <= w_v_last ? '0 : r_v + 1'b1;
      end else begin
        r_h <= r_h + 1'b1;
      end
    end
  end

  // Decode of the pre-increment counters; strobes self-clear after one clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      de          <= 1'b0;
      x           <= '0;
      y           <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      vblank      <= 1'b0;
    end else if (!run) begin
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      de          <= 1'b0;
      x           <= '0;
      y           <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      vblank      <= 1'b0;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (pix_en) begin
        hsync       <= w_hs_on ? HS_POL : ~HS_POL;
        vsync       <= w_vs_on ? VS_POL : ~VS_POL;
        de          <= w_de;
        x           <= w_de ? r_h : '0;
        y           <= w_de ? r_v : '0;
        line_start  <= (r_h == '0);
        frame_start <= (r_h == '0) && (r_v == '0);
        vblank      <= w_vblank;
      end
    end
  end

endmodule
